// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - button sequencing controller for counter_16
// Produces registered inc/clr strobes from debounced buttons; MANUAL/RUN/PAUSE modes.
module count_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int PW       = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       btn_mode,
  output logic       inc,
  output logic       clr,
  output logic [1:0] mode,
  output logic       running
);

  localparam logic [1:0]    S_MANUAL = 2'b00;
  localparam logic [1:0]    S_RUN    = 2'b01;
  localparam logic [1:0]    S_PAUSE  = 2'b10;
  localparam logic [PW-1:0] LAST     = PW'(PRESCALE - 1);

  logic          btn_inc_q, btn_clr_q, btn_mode_q;
  logic          inc_edge, clr_edge, mode_edge;
  logic          tick;
  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    mode_nxt;
  logic          inc_nxt;

  assign inc_edge  = btn_inc  & ~btn_inc_q;
  assign clr_edge  = btn_clr  & ~btn_clr_q;
  assign mode_edge = btn_mode & ~btn_mode_q;
  assign tick      = (mode == S_RUN) && (presc == LAST);

  // Increment decision uses the pre-transition mode; a clear edge drops it.
  assign inc_nxt = ~clr_edge & (tick | ((mode == S_MANUAL) & inc_edge));

  always_comb begin
    mode_nxt = mode;
    if (mode_edge) begin
      case (mode)
        S_MANUAL: mode_nxt = S_RUN;
        S_RUN:    mode_nxt = S_PAUSE;
        default:  mode_nxt = S_MANUAL;
      endcase
    end
  end

  always_comb begin
    presc_nxt = '0;
    if (!clr_edge && mode == S_RUN && !tick)
      presc_nxt = presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_inc_q  <= 1'b0;
      btn_clr_q  <= 1'b0;
      btn_mode_q <= 1'b0;
      presc      <= '0;
      mode       <= S_MANUAL;
      running    <= 1'b0;
      inc        <= 1'b0;
      clr        <= 1'b0;
    end else begin
      btn_inc_q  <= btn_inc;
      btn_clr_q  <= btn_clr;
      btn_mode_q <= btn_mode;
      presc      <= presc_nxt;
      mode       <= mode_nxt;
      running    <= (mode_nxt == S_RUN);
      inc        <= inc_nxt;
      clr        <= clr_edge;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - randomized self-checking bench for count_ctrl
// Reference model tracks mode and last period restart cycle; ticks follow from elapsed cycles.
module tb_count_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_inc = 1'b0, btn_clr = 1'b0, btn_mode = 1'b0;
  logic       inc, clr, running;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_mode, m_k, m_restart;
  bit p_inc, p_clr, p_mode;
  bit e_inc_o, e_clr_o;
  int pulses;

  always #5 clk = ~clk;

  count_ctrl #(.PRESCALE(P), .PW(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_inc(btn_inc), .btn_clr(btn_clr), .btn_mode(btn_mode),
    .inc(inc), .clr(clr), .mode(mode), .running(running)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_restart = 0;
    p_inc = 0; p_clr = 0; p_mode = 0;
    e_inc_o = 0; e_clr_o = 0;
  endtask

  task automatic model_step(input bit bi, input bit bc, input bit bm);
    bit ei, ec, em, tick, man;
    m_k++;
    ei = bi && !p_inc;
    ec = bc && !p_clr;
    em = bm && !p_mode;
    tick = (m_mode == 1) && (m_k > m_restart) && (((m_k - m_restart) % P) == 0);
    man  = (m_mode == 0) && ei;
    e_clr_o = ec;
    e_inc_o = !ec && (tick || man);
    if (ec) m_restart = m_k;
    if (em) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_restart = m_k;
    end
    p_inc = bi; p_clr = bc; p_mode = bm;
  endtask

  task automatic check_outputs();
    check("inc", int'(inc), int'(e_inc_o));
    check("clr", int'(clr), int'(e_clr_o));
    check("mode", int'(mode), m_mode);
    check("running", int'(running), int'(m_mode == 1));
  endtask

  // Inputs change at the falling edge; model and DUT see the same sample.
  task automatic step(input bit bi, input bit bc, input bit bm);
    btn_inc = bi; btn_clr = bc; btn_mode = bm;
    @(posedge clk);
    model_step(bi, bc, bm);
    @(negedge clk);
    check_outputs();
    if (inc) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press_mode();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  initial begin
    model_reset();
    // reset and idle
    #20;
    check("rst_inc", int'(inc), 0);
    check("rst_clr", int'(clr), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_running", int'(running), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(20);

    // manual stepping: three held presses
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      idle(2);
    end
    check("manual_pulses", pulses, 3);

    // auto run: 40 cycles from entry carry 10 ticks
    step(0, 0, 1);
    check("run_mode", int'(mode), 1);
    check("run_running", int'(running), 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    check("run_pulses", pulses, 10);
    press_mode();
    check("pause_mode", int'(mode), 2);
    pulses = 0;
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    idle(1);
    check("pause_pulses", pulses, 0);

    // clear on the same edge as a tick
    press_mode();
    step(0, 0, 1);
    idle(3);
    step(0, 1, 0);
    check("clr_prio_clr", int'(clr), 1);
    check("clr_prio_inc", int'(inc), 0);
    pulses = 0;
    idle(3);
    check("clr_gap", pulses, 0);
    idle(1);
    check("clr_next_inc", int'(inc), 1);
    press_mode();
    press_mode();

    // simultaneous mode + inc from MANUAL
    idle(2);
    check("sim_pre_mode", int'(mode), 0);
    step(1, 0, 1);
    check("sim_inc", int'(inc), 1);
    check("sim_mode", int'(mode), 1);
    idle(2);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_mode", int'(mode), 0);
    check("async_running", int'(running), 0);
    check("async_inc", int'(inc), 0);
    model_reset();

    // mode held through reset release, then wrap
    btn_mode = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 1);
    check("held_mode", int'(mode), 1);
    step(0, 0, 0);
    press_mode();
    check("wrap_pause", int'(mode), 2);
    press_mode();
    check("wrap_manual", int'(mode), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit bi, bc, bm;
      bi = btn_inc  ^ ($urandom_range(0, 3) == 0);
      bc = btn_clr  ^ ($urandom_range(0, 9) == 0);
      bm = btn_mode ^ ($urandom_range(0, 7) == 0);
      step(bi, bc, bm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
